// File: rtl/midi_note_scheduler_pkg.sv
// Shared types for the MIDI note scheduler: FSM encoding, write operation kind,
// and the velocity value that marks a note-off.
package midi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEL   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_SET = 1'b0,
    OP_CLR = 1'b1
  } op_t;

  localparam logic [7:0] NOTE_OFF_VEL = 8'h00;

endpackage

// File: rtl/midi_note_scheduler_slot_finder.sv
// Combinational slot search: lowest free slot, lowest live slot holding a note,
// and lowest live slot with a pending clear request. No wrap-around.
module slot_finder
  import midi_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = 2
) (
  input  logic [NUM_SLOTS-1:0]   slot_valid,
  input  logic [NUM_SLOTS*8-1:0] notes,
  input  logic [7:0]             search_note,
  input  logic [NUM_SLOTS-1:0]   clear_req,
  output logic [SLOT_W-1:0]      free_idx,
  output logic                   free_hit,
  output logic [SLOT_W-1:0]      match_idx,
  output logic                   match_hit,
  output logic [SLOT_W-1:0]      clr_idx,
  output logic                   clr_hit
);

  always_comb begin
    free_idx  = '0;
    free_hit  = 1'b0;
    match_idx = '0;
    match_hit = 1'b0;
    clr_idx   = '0;
    clr_hit   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!free_hit && !slot_valid[i]) begin
        free_hit = 1'b1;
        free_idx = SLOT_W'(i);
      end
      if (!match_hit && slot_valid[i] && (notes[i*8 +: 8] == search_note)) begin
        match_hit = 1'b1;
        match_idx = SLOT_W'(i);
      end
      if (!clr_hit && slot_valid[i] && clear_req[i]) begin
        clr_hit = 1'b1;
        clr_idx = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/midi_note_scheduler.sv
// Slot-based controller between the MIDI decoder, game hit logic and the note
// memory write port. Clears take priority over buffered MIDI events.
module midi_note_scheduler
  import midi_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = 2,
  parameter logic [15:0] MEM_BASE  = 16'h0100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MidiInterrupt,
  input  logic [15:0]          dataMidi,
  output logic                 midi_busy,
  input  logic [NUM_SLOTS-1:0] clear_req,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_wdata,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic                 drop_pulse
);

  state_t state, state_nxt;

  logic                 buf_full;
  logic [15:0]          buf_data;
  logic [NUM_SLOTS*8-1:0] notes;

  op_t                  op, op_nxt;
  logic [SLOT_W-1:0]    slot, slot_nxt;
  logic                 src_midi, src_nxt;
  logic                 load, sel_drop, sel_flush;

  logic [SLOT_W-1:0]    free_idx, match_idx, clr_idx;
  logic                 free_hit, match_hit, clr_hit;

  slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_finder (
    .slot_valid  (slot_valid),
    .notes       (notes),
    .search_note (buf_data[15:8]),
    .clear_req   (clear_req),
    .free_idx    (free_idx),
    .free_hit    (free_hit),
    .match_idx   (match_idx),
    .match_hit   (match_hit),
    .clr_idx     (clr_idx),
    .clr_hit     (clr_hit)
  );

  assign midi_busy = buf_full;
  assign mem_req   = (state == S_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    op_nxt    = OP_SET;
    slot_nxt  = '0;
    src_nxt   = 1'b0;
    sel_drop  = 1'b0;
    sel_flush = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|(clear_req & slot_valid)) || buf_full) state_nxt = S_SEL;
      end
      S_SEL: begin
        state_nxt = S_IDLE;
        if (clr_hit) begin
          load      = 1'b1;
          op_nxt    = OP_CLR;
          slot_nxt  = clr_idx;
          state_nxt = S_WRITE;
        end else if (buf_full) begin
          if (buf_data[7:0] != NOTE_OFF_VEL) begin
            // Retrigger a live copy of the note before taking a fresh slot.
            if (match_hit || free_hit) begin
              load      = 1'b1;
              op_nxt    = OP_SET;
              slot_nxt  = match_hit ? match_idx : free_idx;
              src_nxt   = 1'b1;
              state_nxt = S_WRITE;
            end else begin
              sel_drop  = 1'b1;
              sel_flush = 1'b1;
            end
          end else if (match_hit) begin
            load      = 1'b1;
            op_nxt    = OP_CLR;
            slot_nxt  = match_idx;
            src_nxt   = 1'b1;
            state_nxt = S_WRITE;
          end else begin
            sel_flush = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (mem_gnt) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full   <= 1'b0;
      buf_data   <= '0;
      drop_pulse <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      slot_valid <= '0;
      notes      <= '0;
      op         <= OP_SET;
      slot       <= '0;
      src_midi   <= 1'b0;
    end else begin
      drop_pulse <= sel_drop || (MidiInterrupt && buf_full);

      // A strobe in the cycle the buffer drains still sees it full and is dropped.
      if ((state == S_DONE && src_midi) || sel_flush) begin
        buf_full <= 1'b0;
      end else if (MidiInterrupt && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= dataMidi;
      end

      if (load) begin
        op        <= op_nxt;
        slot      <= slot_nxt;
        src_midi  <= src_nxt;
        mem_addr  <= MEM_BASE + 16'(slot_nxt);
        mem_wdata <= (op_nxt == OP_SET) ? buf_data : '0;
      end

      // Slot state follows the completed write so it is visible during DONE.
      if (state == S_WRITE && mem_gnt) begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (SLOT_W'(i) == slot) begin
            if (op == OP_SET) begin
              slot_valid[i]    <= 1'b1;
              notes[i*8 +: 8]  <= buf_data[15:8];
            end else begin
              slot_valid[i]    <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_note_scheduler.sv
// Bench for midi_note_scheduler: directed scenarios then randomized events,
// compared against a slot-table model of note assignment.
module tb_midi_note_scheduler;

  localparam logic [15:0] BASE = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MidiInterrupt = 1'b0;
  logic [15:0] dataMidi = '0;
  logic [3:0]  clear_req = '0;
  logic        mem_gnt = 1'b1;
  logic        midi_busy, mem_req, drop_pulse;
  logic [15:0] mem_addr, mem_wdata;
  logic [3:0]  slot_valid;

  int errors = 0;
  int checks = 0;
  int gnt_mode = 1;
  int drop_seen = 0;
  int drop_exp = 0;

  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  logic [3:0]  mv = '0;
  logic [7:0]  mn[4];

  midi_note_scheduler #(
    .NUM_SLOTS (4),
    .SLOT_W    (2),
    .MEM_BASE  (16'h0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MidiInterrupt (MidiInterrupt),
    .dataMidi      (dataMidi),
    .midi_busy     (midi_busy),
    .clear_req     (clear_req),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .slot_valid    (slot_valid),
    .drop_pulse    (drop_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0:       mem_gnt = 1'b0;
      1:       mem_gnt = 1'b1;
      default: mem_gnt = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) obs_q.push_back({mem_addr, mem_wdata});
    if (rst_n && drop_pulse) drop_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_on(input logic [7:0] n, input logic [7:0] v);
    int k = -1;
    for (int i = 0; i < 4; i++) if (k < 0 && mv[i] && mn[i] == n) k = i;
    for (int i = 0; i < 4; i++) if (k < 0 && !mv[i]) k = i;
    if (k < 0) drop_exp++;
    else begin
      exp_q.push_back({BASE + 16'(k), n, v});
      mv[k] = 1'b1;
      mn[k] = n;
    end
  endtask

  task automatic model_off(input logic [7:0] n);
    int k = -1;
    for (int i = 0; i < 4; i++) if (k < 0 && mv[i] && mn[i] == n) k = i;
    if (k >= 0) begin
      exp_q.push_back({BASE + 16'(k), 16'h0000});
      mv[k] = 1'b0;
    end
  endtask

  task automatic model_clear(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i] && mv[i]) begin
        exp_q.push_back({BASE + 16'(i), 16'h0000});
        mv[i] = 1'b0;
      end
    end
  endtask

  task automatic model_event(input logic [15:0] d);
    if (d[7:0] == 8'h00) model_off(d[15:8]);
    else model_on(d[15:8], d[7:0]);
  endtask

  task automatic strobe(input logic [15:0] d);
    @(negedge clk);
    MidiInterrupt = 1'b1;
    dataMidi = d;
    @(negedge clk);
    MidiInterrupt = 1'b0;
    dataMidi = 16'($urandom);
  endtask

  task automatic settle(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (c >= 6 && obs_q.size() >= exp_q.size() && !mem_req && !midi_busy) done = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk({tag, " settle_timeout"}, 32'(done), 32'h1);
  endtask

  task automatic compare(input string tag);
    chk({tag, " nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, " write"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    chk({tag, " slot_valid"}, 32'(slot_valid), 32'(mv));
    chk({tag, " drops"}, 32'(drop_seen), 32'(drop_exp));
  endtask

  task automatic do_midi(input logic [15:0] d, input string tag);
    model_event(d);
    strobe(d);
    settle(tag);
    compare(tag);
  endtask

  task automatic do_clear(input logic [3:0] m, input string tag);
    model_clear(m);
    @(negedge clk);
    clear_req = m;
    settle(tag);
    clear_req = '0;
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    int stable;
    bit seen;
    logic [7:0] n;
    int r;

    for (int i = 0; i < 4; i++) mn[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst mem_addr", 32'(mem_addr), 32'h0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst slot_valid", 32'(slot_valid), 32'h0);
    chk("rst midi_busy", 32'(midi_busy), 32'h0);
    chk("rst drop_pulse", 32'(drop_pulse), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First note-on: cycle-exact latency with grant tied high
    model_event(16'h3C40);
    @(negedge clk);
    MidiInterrupt = 1'b1;
    dataMidi = 16'h3C40;
    @(negedge clk);
    MidiInterrupt = 1'b0;
    dataMidi = 16'hA5A5;
    chk("lat c1 busy", 32'(midi_busy), 32'h1);
    chk("lat c1 req", 32'(mem_req), 32'h0);
    @(negedge clk);
    chk("lat c2 req", 32'(mem_req), 32'h0);
    @(negedge clk);
    chk("lat c3 req", 32'(mem_req), 32'h1);
    chk("lat c3 addr", 32'(mem_addr), 32'h0100);
    chk("lat c3 wdata", 32'(mem_wdata), 32'h3C40);
    @(negedge clk);
    chk("lat c4 slot_valid", 32'(slot_valid), 32'h1);
    chk("lat c4 addr", 32'(mem_addr), 32'h0100);
    chk("lat c4 wdata", 32'(mem_wdata), 32'h3C40);
    chk("lat c4 busy", 32'(midi_busy), 32'h1);
    @(negedge clk);
    chk("lat c5 busy", 32'(midi_busy), 32'h0);
    settle("lat");
    compare("lat");

    // Fill remaining slots, then a note-on with no free slot
    do_midi(16'h3E50, "fill1");
    do_midi(16'h4050, "fill2");
    do_midi(16'h4150, "fill3");
    do_midi(16'h4350, "full_drop");

    // Clear and note-on in the same cycle: clear first, then MIDI
    model_clear(4'b0100);
    model_event(16'h4320);
    @(negedge clk);
    clear_req = 4'b0100;
    MidiInterrupt = 1'b1;
    dataMidi = 16'h4320;
    @(negedge clk);
    MidiInterrupt = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (!slot_valid[2]) seen = 1'b1;
      else @(negedge clk);
    end
    chk("clrprio slot2 cleared", 32'(seen), 32'h1);
    chk("clrprio one write before midi", 32'(obs_q.size()), 32'h1);
    clear_req = '0;
    settle("clrprio");
    compare("clrprio");

    // Note-off of a live note, then the same note-off again
    do_midi(16'h3C00, "noteoff");
    do_midi(16'h3C00, "noteoff_rpt");

    // Second strobe while busy is dropped; buffered note unchanged
    model_event(16'h4550);
    drop_exp++;
    @(negedge clk);
    MidiInterrupt = 1'b1;
    dataMidi = 16'h4550;
    @(negedge clk);
    dataMidi = 16'h4660;
    chk("busy2 busy", 32'(midi_busy), 32'h1);
    @(negedge clk);
    MidiInterrupt = 1'b0;
    chk("busy2 drop hi", 32'(drop_pulse), 32'h1);
    @(negedge clk);
    chk("busy2 drop lo", 32'(drop_pulse), 32'h0);
    settle("busy2");
    compare("busy2");

    // Grant withheld, then asynchronous reset in the middle of the write
    gnt_mode = 0;
    repeat (2) @(negedge clk);
    strobe(16'h3E11);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (mem_req) seen = 1'b1;
      else @(negedge clk);
    end
    chk("gntlow req seen", 32'(seen), 32'h1);
    stable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0101 && mem_wdata == 16'h3E11) stable++;
    end
    chk("gntlow hold stable", 32'(stable), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'h0);
    chk("midrst slot_valid", 32'(slot_valid), 32'h0);
    chk("midrst busy", 32'(midi_busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mv = '0;
    exp_q.delete();
    chk("midrst no write", 32'(obs_q.size()), 32'h0);
    obs_q.delete();
    gnt_mode = 1;
    stable = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!mem_req) stable++;
    end
    chk("postrst idle", 32'(stable), 32'd8);
    compare("postrst");

    // Randomized events with random grant timing
    gnt_mode = 2;
    for (int e = 0; e < 60; e++) begin
      r = int'($urandom_range(9));
      n = 8'h3C + 8'($urandom_range(5));
      if (r < 5)      do_midi({n, 8'($urandom_range(127, 1))}, "rand_on");
      else if (r < 8) do_midi({n, 8'h00}, "rand_off");
      else            do_clear(4'($urandom_range(15)), "rand_clr");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
